if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32IF pipeline. It generates the PC, issues one instruction-memory read at a time over a valid/ready request and response pair, and loads the IF/ID pipeline register that drives the decoder's `instr` input. It handles hazard stalls, EX-stage branch and jump redirects, trap and mret redirects, and WFI parking.

---
 rtl/if_stage.sv | 199 +++++++++++++++++++
 tb/tb_if_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage RV32IF pipeline.
// It keeps one instruction-memory read in flight at a time and loads the
// IF/ID register. Redirect priority is trap_take, then flush_id, then the
// sequential PC. WFI parks the fetcher until a trap.
// Optional feature macro: IF_SKID_BUF_EN. When it is defined, a 1-entry skid
// buffer holds a response that arrives while ID is stalled. When it is
// undefined, that response is dropped and its PC is fetched again.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    input  logic        stall_id,
    input  logic        flush_id,
    input  logic [31:0] redirect_pc,
    input  logic        trap_take,
    input  logic [31:0] trap_pc,
    input  logic        wfi_hold,
    output logic [31:0] pc_ID,
    output logic [31:0] instr_ID,
    output logic        valid_ID
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_PARK} state_t;

    localparam logic [31:0] BOOT_PC = RESET_PC & ~32'd3;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] req_pc, req_pc_n;
    logic [31:0] seq_pc;
    logic [31:0] target;
    logic        redirect;
    logic        fire;
    logic        rsp_ok;
    logic        hold_req_n;   // next cycle must not issue a request

    assign redirect = trap_take | flush_id;
    // trap_take wins over flush_id. Targets are always word aligned.
    assign target   = (trap_take ? trap_pc : redirect_pc) & ~32'd3;
    // im_req is only ever high in REQ, so a handshake means acceptance there.
    assign fire     = im_req & im_ready;
    // Only WAIT owns a response. Data seen in DRAIN/REQ/PARK is stale.
    assign rsp_ok   = im_rvalid & (state == S_WAIT);
    assign seq_pc   = req_pc + 32'd4;

`ifdef IF_SKID_BUF_EN
    logic        skid_full, skid_full_n;
    logic [31:0] skid_pc, skid_instr;

    // The buffer fills when a response lands during a stall. It is consumed
    // on the first unstalled cycle and is wiped by any redirect.
    assign skid_full_n = ~redirect & stall_id & (skid_full | rsp_ok);
    assign hold_req_n  = skid_full_n;
`else
    logic replay, replay_n;

    // Replay hold: once a response has been dropped for a stall, refetching
    // is blocked until stall_id falls.
    assign hold_req_n = replay_n;
`endif

    // Next-state logic for the fetch FSM and the fetch/request PCs.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_pc_n   = req_pc;
`ifndef IF_SKID_BUF_EN
        replay_n   = replay & stall_id & ~redirect;
`endif
        case (state)
            S_REQ: begin
                if (redirect) begin
                    fetch_pc_n = target;
                    // An address already accepted this cycle must still be drained.
                    state_n    = fire ? S_DRAIN : S_REQ;
                end else if (fire) begin
                    state_n  = S_WAIT;
                    req_pc_n = fetch_pc;
                end else if (wfi_hold) begin
                    state_n = S_PARK;
                end
            end
            S_WAIT: begin
                if (im_rvalid) begin
                    if (redirect) begin
                        // The response dies with the flushed IF/ID contents.
                        fetch_pc_n = target;
                        state_n    = S_REQ;
                    end else begin
`ifdef IF_SKID_BUF_EN
                        fetch_pc_n = seq_pc;
`else
                        if (stall_id) begin
                            fetch_pc_n = req_pc;
                            replay_n   = 1'b1;
                        end else begin
                            fetch_pc_n = seq_pc;
                        end
`endif
                        state_n = wfi_hold ? S_PARK : S_REQ;
                    end
                end else if (redirect) begin
                    fetch_pc_n = target;
                    state_n    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redirect) fetch_pc_n = target;
                if (im_rvalid) state_n = S_REQ;
            end
            S_PARK: begin
                if (trap_take) begin
                    fetch_pc_n = target;
                    state_n    = S_REQ;
                end else if (flush_id) begin
                    fetch_pc_n = target;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

    // Fetch FSM state and registered memory request outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= BOOT_PC;
            req_pc   <= BOOT_PC;
            im_req   <= 1'b0;
            im_addr  <= BOOT_PC;
`ifndef IF_SKID_BUF_EN
            replay   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_pc   <= req_pc_n;
            im_req   <= (state_n == S_REQ) & ~hold_req_n;
            im_addr  <= fetch_pc_n;
`ifndef IF_SKID_BUF_EN
            replay   <= replay_n;
`endif
        end
    end

`ifdef IF_SKID_BUF_EN
    // Skid buffer capture of a response that arrives while ID is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_full  <= 1'b0;
            skid_pc    <= 32'd0;
            skid_instr <= NOP_INSTR;
        end else begin
            skid_full <= skid_full_n;
            if (stall_id & rsp_ok & ~redirect) begin
                skid_pc    <= req_pc;
                skid_instr <= im_rdata;
            end
        end
    end
`endif

    // IF/ID register: kill first, then hold, then skid, then response, else bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_ID    <= 32'd0;
            instr_ID <= NOP_INSTR;
            valid_ID <= 1'b0;
        end else if (redirect) begin
            instr_ID <= NOP_INSTR;
            valid_ID <= 1'b0;
        end else if (stall_id) begin
            pc_ID    <= pc_ID;
            instr_ID <= instr_ID;
            valid_ID <= valid_ID;
`ifdef IF_SKID_BUF_EN
        end else if (skid_full) begin
            pc_ID    <= skid_pc;
            instr_ID <= skid_instr;
            valid_ID <= 1'b1;
`endif
        end else if (rsp_ok) begin
            pc_ID    <= req_pc;
            instr_ID <= im_rdata;
            valid_ID <= 1'b1;
        end else begin
            instr_ID <= NOP_INSTR;
            valid_ID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage. A zero-wait memory model returns
// mem[a] = a + 32'h100. Tests can switch it off and drive the handshake by hand.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        stall_id;
    logic        flush_id;
    logic [31:0] redirect_pc;
    logic        trap_take;
    logic [31:0] trap_pc;
    logic        wfi_hold;
    logic [31:0] pc_ID;
    logic [31:0] instr_ID;
    logic        valid_ID;

    logic        auto_mem;
    logic        man_ready, man_rvalid;
    logic [31:0] man_rdata;
    logic        pend;
    logic [31:0] paddr;

    int nvec = 0;
    int nerr = 0;

    if_stage dut (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .stall_id(stall_id), .flush_id(flush_id), .redirect_pc(redirect_pc),
        .trap_take(trap_take), .trap_pc(trap_pc), .wfi_hold(wfi_hold),
        .pc_ID(pc_ID), .instr_ID(instr_ID), .valid_ID(valid_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait memory: accept immediately, answer on the next cycle.
    assign im_ready  = auto_mem ? im_req : man_ready;
    assign im_rvalid = auto_mem ? pend : man_rvalid;
    assign im_rdata  = auto_mem ? (paddr + 32'h100) : man_rdata;

    always @(posedge clk) begin
        pend  <= im_req & im_ready;
        paddr <= im_addr;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        auto_mem = 1'b1; man_ready = 1'b0; man_rvalid = 1'b0; man_rdata = 32'd0;
        stall_id = 1'b0; flush_id = 1'b0; redirect_pc = 32'd0;
        trap_take = 1'b0; trap_pc = 32'd0; wfi_hold = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        nvec++; if ({im_req, im_addr} !== {1'b0, 32'h0}) begin nerr++;
            $display("FAIL reset_req: got req=%b addr=%h want req=0 addr=0", im_req, im_addr); end
        nvec++; if ({valid_ID, pc_ID, instr_ID} !== {1'b0, 32'h0, NOP}) begin nerr++;
            $display("FAIL reset_ifid: got v=%b pc=%h i=%h want v=0 pc=0 i=%h", valid_ID, pc_ID, instr_ID, NOP); end
    endtask

    task automatic test_sequential;
        do_reset();
        tick();
        nvec++; if ({im_req, im_addr} !== {1'b1, 32'h0}) begin nerr++;
            $display("FAIL seq_first_req: got req=%b addr=%h want req=1 addr=0", im_req, im_addr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            nvec++; if (valid_ID !== 1'b0) begin nerr++;
                $display("FAIL seq_bubble%0d: got valid=%b want 0", k, valid_ID); end
            tick();
            nvec++; if ({valid_ID, pc_ID, instr_ID, im_req, im_addr} !==
                        {1'b1, 32'(4*k), 32'(32'h100 + 4*k), 1'b1, 32'(4*k + 4)}) begin nerr++;
                $display("FAIL seq_instr%0d: got v=%b pc=%h i=%h req=%b addr=%h want v=1 pc=%h i=%h req=1 addr=%h",
                         k, valid_ID, pc_ID, instr_ID, im_req, im_addr, 4*k, 32'h100 + 4*k, 4*k + 4); end
        end
    endtask

    task automatic test_flush_wait;
        do_reset();
        tick();                              // REQ, addr 0
        auto_mem = 1'b0; man_ready = 1'b1;
        tick();                              // accepted -> WAIT
        man_ready = 1'b0; flush_id = 1'b1; redirect_pc = 32'h201;
        tick();                              // redirect in WAIT -> DRAIN
        flush_id = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD;
        nvec++; if ({valid_ID, instr_ID} !== {1'b0, NOP}) begin nerr++;
            $display("FAIL flush_bubble: got v=%b i=%h want v=0 i=%h", valid_ID, instr_ID, NOP); end
        tick();                              // stale response drained
        man_rvalid = 1'b0; auto_mem = 1'b1;
        nvec++; if ({valid_ID, instr_ID} !== {1'b0, NOP}) begin nerr++;
            $display("FAIL flush_drop_dead: got v=%b i=%h want v=0 i=%h", valid_ID, instr_ID, NOP); end
        nvec++; if ({im_req, im_addr} !== {1'b1, 32'h200}) begin nerr++;
            $display("FAIL flush_target: got req=%b addr=%h want req=1 addr=200", im_req, im_addr); end
        tick(); tick();
        nvec++; if ({valid_ID, pc_ID, instr_ID} !== {1'b1, 32'h200, 32'h300}) begin nerr++;
            $display("FAIL flush_resume: got v=%b pc=%h i=%h want v=1 pc=200 i=300", valid_ID, pc_ID, instr_ID); end
    endtask

    task automatic test_stall;
        do_reset();
        for (int k = 0; k < 5; k++) tick();  // instr 0x104 in ID, req addr 8
        stall_id = 1'b1; auto_mem = 1'b0; man_ready = 1'b1;
        tick();                              // PC 8 accepted while stalled
        nvec++; if ({valid_ID, pc_ID, instr_ID} !== {1'b1, 32'h4, 32'h104}) begin nerr++;
            $display("FAIL stall_hold1: got v=%b pc=%h i=%h want v=1 pc=4 i=104", valid_ID, pc_ID, instr_ID); end
        man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h13579;
        tick();                              // response lands mid-stall
        man_rvalid = 1'b0;
        nvec++; if ({instr_ID, im_req} !== {32'h104, 1'b0}) begin nerr++;
            $display("FAIL stall_hold2: got i=%h req=%b want i=104 req=0", instr_ID, im_req); end
        tick();                              // third stalled cycle
        stall_id = 1'b0;
        nvec++; if ({instr_ID, im_req} !== {32'h104, 1'b0}) begin nerr++;
            $display("FAIL stall_hold3: got i=%h req=%b want i=104 req=0", instr_ID, im_req); end
        tick();                              // first cycle after release
        auto_mem = 1'b1;
`ifdef IF_SKID_BUF_EN
        nvec++; if ({valid_ID, pc_ID, instr_ID} !== {1'b1, 32'h8, 32'h13579}) begin nerr++;
            $display("FAIL skid_deliver: got v=%b pc=%h i=%h want v=1 pc=8 i=13579", valid_ID, pc_ID, instr_ID); end
        nvec++; if ({im_req, im_addr} !== {1'b1, 32'hC}) begin nerr++;
            $display("FAIL skid_next_req: got req=%b addr=%h want req=1 addr=c", im_req, im_addr); end
        tick(); tick();
        nvec++; if ({valid_ID, pc_ID, instr_ID} !== {1'b1, 32'hC, 32'h10C}) begin nerr++;
            $display("FAIL skid_follow: got v=%b pc=%h i=%h want v=1 pc=c i=10c", valid_ID, pc_ID, instr_ID); end
`else
        nvec++; if (valid_ID !== 1'b0) begin nerr++;
            $display("FAIL replay_bubble: got v=%b want 0", valid_ID); end
        nvec++; if ({im_req, im_addr} !== {1'b1, 32'h8}) begin nerr++;
            $display("FAIL replay_req: got req=%b addr=%h want req=1 addr=8", im_req, im_addr); end
        tick(); tick();
        nvec++; if ({valid_ID, pc_ID, instr_ID} !== {1'b1, 32'h8, 32'h108}) begin nerr++;
            $display("FAIL replay_deliver: got v=%b pc=%h i=%h want v=1 pc=8 i=108", valid_ID, pc_ID, instr_ID); end
`endif
    endtask

    task automatic test_trap_priority;
        do_reset();
        tick();                              // REQ, addr 0
        auto_mem = 1'b0; man_ready = 1'b0;
        trap_take = 1'b1; trap_pc = 32'h80; flush_id = 1'b1; redirect_pc = 32'h40;
        tick();
        trap_take = 1'b0; flush_id = 1'b0; auto_mem = 1'b1;
        nvec++; if ({im_req, im_addr} !== {1'b1, 32'h80}) begin nerr++;
            $display("FAIL trap_priority: got req=%b addr=%h want req=1 addr=80", im_req, im_addr); end
        nvec++; if (valid_ID !== 1'b0) begin nerr++;
            $display("FAIL trap_bubble: got v=%b want 0", valid_ID); end
    endtask

    task automatic test_wfi;
        do_reset();
        wfi_hold = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            nvec++; if (im_req !== 1'b0) begin nerr++;
                $display("FAIL wfi_park%0d: got req=%b want 0", k, im_req); end
        end
        trap_take = 1'b1; trap_pc = 32'h1C;
        tick();
        trap_take = 1'b0; wfi_hold = 1'b0;
        nvec++; if ({im_req, im_addr} !== {1'b1, 32'h1C}) begin nerr++;
            $display("FAIL wfi_wake: got req=%b addr=%h want req=1 addr=1c", im_req, im_addr); end
    endtask

    task automatic test_wrap;
        do_reset();
        tick();
        auto_mem = 1'b0; man_ready = 1'b0; flush_id = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        flush_id = 1'b0; auto_mem = 1'b1;
        nvec++; if ({im_req, im_addr} !== {1'b1, 32'hFFFF_FFFC}) begin nerr++;
            $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffffc", im_req, im_addr); end
        tick(); tick();
        nvec++; if ({valid_ID, pc_ID, instr_ID, im_addr} !== {1'b1, 32'hFFFF_FFFC, 32'hFC, 32'h0}) begin nerr++;
            $display("FAIL wrap_next: got v=%b pc=%h i=%h addr=%h want v=1 pc=fffffffc i=fc addr=0",
                     valid_ID, pc_ID, instr_ID, im_addr); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        tick(); tick();                      // in WAIT for addr 0
        auto_mem = 1'b0; man_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        nvec++; if ({im_req, im_addr, valid_ID, instr_ID} !== {1'b0, 32'h0, 1'b0, NOP}) begin nerr++;
            $display("FAIL midrst_async: got req=%b addr=%h v=%b i=%h want req=0 addr=0 v=0 i=%h",
                     im_req, im_addr, valid_ID, instr_ID, NOP); end
        man_rvalid = 1'b1; man_rdata = 32'hBAD;
        tick();
        rst = 1'b0;                          // late rvalid still high
        tick();
        man_rvalid = 1'b0; auto_mem = 1'b1;
        nvec++; if ({valid_ID, instr_ID} !== {1'b0, NOP}) begin nerr++;
            $display("FAIL midrst_late_rsp: got v=%b i=%h want v=0 i=%h", valid_ID, instr_ID, NOP); end
        nvec++; if ({im_req, im_addr} !== {1'b1, 32'h0}) begin nerr++;
            $display("FAIL midrst_first_req: got req=%b addr=%h want req=1 addr=0", im_req, im_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_flush_wait();
        test_stall();
        test_trap_priority();
        test_wfi();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
